vga_rect_engine: RTL and testbench

Bus-initiator drawing engine for the VGA peripheral. It accepts a rectangle command from the local side and fills the rectangle's pixels into the frame buffer. It does this by issuing write transactions on the shared 8-bit microprocessor bus to the VGA peripheral's register bank (X, Y|write-enable, colour). The block sits on the bus next to the CPU and takes the bus only while granted by the top-level arbiter.

---
 rtl/vga_rect_engine.sv | 204 ++++++++++++++++++++
 tb/tb_vga_rect_engine.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_engine.sv
// vga_rect_engine: bus initiator that fills a rectangle into the VGA frame buffer through
// the peripheral's X / {WE,Y} / colour registers. Border-only mode: define VGA_RECT_OUTLINE_EN.
module vga_rect_engine (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [7:0] CMD_X0,
    input  logic [6:0] CMD_Y0,
    input  logic [7:0] CMD_W,
    input  logic [6:0] CMD_H,
    input  logic       CMD_COLOUR,
`ifdef VGA_RECT_OUTLINE_EN
    input  logic       CMD_OUTLINE,
`endif
    output logic       BUSY,
    output logic       DONE,
    output logic       BUS_REQ,
    input  logic       BUS_GNT,
    output logic [7:0] BUS_ADDR,
    output logic       BUS_WE,
    inout  wire  [7:0] BUS_DATA
);

    localparam logic [7:0] BASE_ADDR = 8'hB0;
    localparam logic [8:0] FB_W      = 9'd160;
    localparam logic [7:0] FB_H      = 8'd120;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_COLOUR = 3'd1,
        S_SETX   = 3'd2,
        S_WEON   = 3'd3,
        S_WEOFF  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // A pixel is written only if it lands inside the frame buffer (and on the border in outline mode).
    function automatic logic pix_vis(input logic [7:0] x0, input logic [6:0] y0,
                                     input logic [7:0] xoff, input logic [6:0] yoff,
                                     input logic [7:0] w, input logic [6:0] h,
                                     input logic outline);
        logic [8:0] x;
        logic [7:0] y;
        logic       edge_px;
        x       = {1'b0, x0} + {1'b0, xoff};
        y       = {1'b0, y0} + {1'b0, yoff};
        edge_px = (xoff == 8'd0) || (xoff == w - 8'd1) || (yoff == 7'd0) || (yoff == h - 7'd1);
        pix_vis = (x < FB_W) && (y < FB_H) && (!outline || edge_px);
    endfunction

    state_t     state_r;
    logic [7:0] x0_r, w_r, xoff_r;
    logic [6:0] y0_r, h_r, yoff_r;
    logic       colour_r;
    logic       outline_s;
    logic       wr_r, req_r, ready_r, busy_r, done_r;
    logic [7:0] addr_r, data_r;

    logic       last_col_s, last_pix_s, cur_vis_s, nxt_vis_s, adv_s;
    logic [7:0] nxt_xoff_s, cur_x_s, nxt_x_s;
    logic [6:0] nxt_yoff_s, cur_y_s;

`ifdef VGA_RECT_OUTLINE_EN
    logic outline_r;

    // Outline flag is captured with the rest of the command.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            outline_r <= 1'b0;
        end else if (state_r == S_IDLE && CMD_VALID) begin
            outline_r <= CMD_OUTLINE;
        end else begin
            outline_r <= outline_r;
        end
    end
    assign outline_s = outline_r;
`else
    assign outline_s = 1'b0;
`endif

    // Scan position bookkeeping; coordinates are only put on the bus when the pixel is visible.
    assign last_col_s = (xoff_r == w_r - 8'd1);
    assign last_pix_s = last_col_s && (yoff_r == h_r - 7'd1);
    assign nxt_xoff_s = last_col_s ? 8'd0 : xoff_r + 8'd1;
    assign nxt_yoff_s = last_col_s ? yoff_r + 7'd1 : yoff_r;
    assign cur_x_s    = x0_r + xoff_r;
    assign cur_y_s    = y0_r + yoff_r;
    assign nxt_x_s    = x0_r + nxt_xoff_s;
    assign cur_vis_s  = pix_vis(x0_r, y0_r, xoff_r, yoff_r, w_r, h_r, outline_s);
    assign nxt_vis_s  = pix_vis(x0_r, y0_r, nxt_xoff_s, nxt_yoff_s, w_r, h_r, outline_s);
    // Skipped pixels advance without needing the bus; real writes advance only when granted.
    assign adv_s      = (state_r == S_SETX && !wr_r) || (state_r == S_WEOFF && BUS_GNT);

    // Main sequencer: every bus field is registered one cycle ahead of the write it describes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r  <= S_IDLE;
            x0_r     <= 8'd0;
            y0_r     <= 7'd0;
            w_r      <= 8'd0;
            h_r      <= 7'd0;
            colour_r <= 1'b0;
            xoff_r   <= 8'd0;
            yoff_r   <= 7'd0;
            wr_r     <= 1'b0;
            addr_r   <= 8'd0;
            data_r   <= 8'd0;
            req_r    <= 1'b0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (CMD_VALID) begin
                        x0_r     <= CMD_X0;
                        y0_r     <= CMD_Y0;
                        w_r      <= CMD_W;
                        h_r      <= CMD_H;
                        colour_r <= CMD_COLOUR;
                        xoff_r   <= 8'd0;
                        yoff_r   <= 7'd0;
                        ready_r  <= 1'b0;
                        busy_r   <= 1'b1;
                        if (CMD_W == 8'd0 || CMD_H == 7'd0) begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= S_COLOUR;
                            req_r   <= 1'b1;
                            wr_r    <= 1'b1;
                            addr_r  <= BASE_ADDR + 8'd2;
                            data_r  <= {7'd0, CMD_COLOUR};
                        end
                    end
                end
                S_COLOUR: begin
                    if (BUS_GNT) begin
                        state_r <= S_SETX;
                        wr_r    <= cur_vis_s;
                        addr_r  <= cur_vis_s ? BASE_ADDR : 8'd0;
                        data_r  <= cur_vis_s ? cur_x_s : 8'd0;
                    end
                end
                S_SETX: begin
                    if (wr_r && BUS_GNT) begin
                        state_r <= S_WEON;
                        addr_r  <= BASE_ADDR + 8'd1;
                        data_r  <= {1'b1, cur_y_s};
                    end
                end
                S_WEON: begin
                    if (BUS_GNT) begin
                        state_r <= S_WEOFF;
                        data_r  <= {1'b0, cur_y_s};
                    end
                end
                S_WEOFF: begin
                    state_r <= S_WEOFF;
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    wr_r    <= 1'b0;
                    req_r   <= 1'b0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
            if (adv_s) begin
                if (last_pix_s) begin
                    state_r <= S_DONE;
                    done_r  <= 1'b1;
                    req_r   <= 1'b0;
                    wr_r    <= 1'b0;
                    addr_r  <= 8'd0;
                    data_r  <= 8'd0;
                end else begin
                    state_r <= S_SETX;
                    xoff_r  <= nxt_xoff_s;
                    yoff_r  <= nxt_yoff_s;
                    wr_r    <= nxt_vis_s;
                    addr_r  <= nxt_vis_s ? BASE_ADDR : 8'd0;
                    data_r  <= nxt_vis_s ? nxt_x_s : 8'd0;
                end
            end
        end
    end

    assign CMD_READY = ready_r;
    assign BUSY      = busy_r;
    assign DONE      = done_r;
    assign BUS_REQ   = req_r;
    assign BUS_WE    = wr_r & BUS_GNT;
    assign BUS_ADDR  = BUS_WE ? addr_r : 8'h00;
    assign BUS_DATA  = BUS_WE ? data_r : 8'hzz;

endmodule

// File: tb/tb_vga_rect_engine.sv
// Directed bench for vga_rect_engine: bus monitor plus frame-buffer model, hand-computed write lists.
module tb_vga_rect_engine;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CMD_VALID = 1'b0;
    logic [7:0] CMD_X0 = 8'd0;
    logic [6:0] CMD_Y0 = 7'd0;
    logic [7:0] CMD_W = 8'd0;
    logic [6:0] CMD_H = 7'd0;
    logic       CMD_COLOUR = 1'b0;
`ifdef VGA_RECT_OUTLINE_EN
    logic       CMD_OUTLINE = 1'b0;
`endif
    logic       BUS_GNT = 1'b1;
    logic       CMD_READY, BUSY, DONE, BUS_REQ, BUS_WE;
    logic [7:0] BUS_ADDR;
    wire  [7:0] BUS_DATA;

    localparam logic [7:0] REL = 8'hFF;  // value of the released bus through the pull-ups

    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (BUS_DATA[i]);
    end

    vga_rect_engine dut (
        .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_X0(CMD_X0), .CMD_Y0(CMD_Y0), .CMD_W(CMD_W), .CMD_H(CMD_H),
        .CMD_COLOUR(CMD_COLOUR),
`ifdef VGA_RECT_OUTLINE_EN
        .CMD_OUTLINE(CMD_OUTLINE),
`endif
        .BUSY(BUSY), .DONE(DONE), .BUS_REQ(BUS_REQ), .BUS_GNT(BUS_GNT),
        .BUS_ADDR(BUS_ADDR), .BUS_WE(BUS_WE), .BUS_DATA(BUS_DATA)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor and frame-buffer model of the VGA peripheral
    logic [15:0] wlog[$];
    int          gnt_viol, addr_viol;
    bit          req_seen;
    logic        fb [0:119][0:159];
    logic [7:0]  pm_x = 8'd0;
    logic        pm_c = 1'b0;

    always @(negedge CLK) begin
        if (BUS_REQ === 1'b1) req_seen = 1'b1;
        if (BUS_GNT == 1'b0 && (BUS_WE !== 1'b0 || BUS_DATA !== REL)) gnt_viol++;
        if (BUS_WE !== 1'b1 && (BUS_ADDR !== 8'h00 || BUS_DATA !== REL)) addr_viol++;
        if (BUS_WE === 1'b1) begin
            wlog.push_back({BUS_ADDR, BUS_DATA});
            case (BUS_ADDR)
                8'hB0: pm_x = BUS_DATA;
                8'hB2: pm_c = BUS_DATA[0];
                8'hB1: if (BUS_DATA[7] && pm_x < 8'd160 && BUS_DATA[6:0] < 7'd120)
                           fb[BUS_DATA[6:0]][pm_x] = pm_c;
                default: ;
            endcase
        end
    end

    bit gnt_toggle = 1'b0;
    int gidx = 0;
    always @(posedge CLK) begin
        #1;
        if (gnt_toggle) begin
            BUS_GNT = (gidx == 0 || gidx == 3);
            gidx = (gidx + 1) % 4;
        end else begin
            BUS_GNT = 1'b1;
        end
    end

    task automatic clear_obs();
        wlog.delete();
        req_seen  = 1'b0;
        gnt_viol  = 0;
        addr_viol = 0;
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                fb[y][x] = 1'b0;
    endtask

    // Issue one command, scramble the command fields after accept, and time DONE from the accept edge.
    task automatic run_cmd(input string tag, input logic [7:0] x0, input logic [6:0] y0,
                           input logic [7:0] w, input logic [6:0] h, input logic c,
                           input logic ol, output int lat);
        clear_obs();
        @(posedge CLK); #1;
        CMD_X0 = x0; CMD_Y0 = y0; CMD_W = w; CMD_H = h; CMD_COLOUR = c;
`ifdef VGA_RECT_OUTLINE_EN
        CMD_OUTLINE = ol;
`endif
        CMD_VALID = 1'b1;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        CMD_X0 = ~x0; CMD_Y0 = ~y0; CMD_W = 8'd1; CMD_H = 7'd1; CMD_COLOUR = ~c;
        lat = 0;
        while (lat < 400) begin
            @(negedge CLK);
            lat++;
            if (DONE === 1'b1) break;
        end
        check_eq({tag, "_done_seen"}, {31'd0, DONE}, 32'd1);
        check_eq({tag, "_busy_in_done"}, {31'd0, BUSY}, 32'd1);
        @(negedge CLK);
        check_eq({tag, "_done_pulse_end"}, {30'd0, DONE, CMD_READY}, 32'd1);
        if (ol) lat = lat + 0;
    endtask

    task automatic cmp_log(input string tag, input logic [15:0] exp[$]);
        check_eq({tag, "_nwrites"}, wlog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < wlog.size(); i++)
            check_eq($sformatf("%s_w%0d", tag, i), {16'd0, wlog[i]}, {16'd0, exp[i]});
    endtask

    logic [15:0] exp1[$] = '{16'hB201, 16'hB00A, 16'hB194, 16'hB114, 16'hB00B, 16'hB194, 16'hB114,
                             16'hB00A, 16'hB195, 16'hB115, 16'hB00B, 16'hB195, 16'hB115};
    logic [15:0] exp2[$] = '{16'hB201, 16'hB09E, 16'hB1F7, 16'hB177, 16'hB09F, 16'hB1F7, 16'hB177};

    initial begin
        int lat;
        int dcnt;
        int ones;
        // Reset with a command offered: nothing may be accepted
        CMD_VALID = 1'b1; CMD_W = 8'd2; CMD_H = 7'd2;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_ready_busy_done", {29'd0, CMD_READY, BUSY, DONE}, 32'd4);
        check_eq("rst_req_we", {30'd0, BUS_REQ, BUS_WE}, 32'd0);
        check_eq("rst_addr", {24'd0, BUS_ADDR}, 32'd0);
        check_eq("rst_data_released", {24'd0, BUS_DATA}, {24'd0, REL});
        @(posedge CLK); #1;
        RESET = 1'b0; CMD_VALID = 1'b0;

        // 2x2 fill at (10,20), grant tied high
        run_cmd("fill", 8'd10, 7'd20, 8'd2, 7'd2, 1'b1, 1'b0, lat);
        check_eq("fill_latency", lat, 32'd14);
        cmp_log("fill", exp1);
        check_eq("fill_fb", {28'd0, fb[20][10], fb[20][11], fb[21][10], fb[21][11]}, 32'hF);
        check_eq("fill_req_seen", {31'd0, req_seen}, 32'd1);
        check_eq("fill_idle_bus", addr_viol, 32'd0);

        // Clipping at the bottom-right corner
        run_cmd("clip", 8'd158, 7'd119, 8'd4, 7'd3, 1'b1, 1'b0, lat);
        check_eq("clip_latency", lat, 32'd18);
        cmp_log("clip", exp2);
        check_eq("clip_fb", {30'd0, fb[119][158], fb[119][159]}, 32'h3);

        // Zero-width command
        run_cmd("zero", 8'd20, 7'd5, 8'd0, 7'd5, 1'b1, 1'b0, lat);
        check_eq("zero_latency", lat, 32'd1);
        check_eq("zero_nwrites", wlog.size(), 32'd0);
        check_eq("zero_no_req", {31'd0, req_seen}, 32'd0);

        // Same fill with grant toggling 1,0,0,1
        gnt_toggle = 1'b1; gidx = 0;
        run_cmd("gnt", 8'd10, 7'd20, 8'd2, 7'd2, 1'b1, 1'b0, lat);
        gnt_toggle = 1'b0;
        cmp_log("gnt", exp1);
        check_eq("gnt_released_while_low", gnt_viol, 32'd0);
        check_eq("gnt_idle_bus", addr_viol, 32'd0);

        // Reset during WEON of the second pixel
        clear_obs();
        @(posedge CLK); #1;
        CMD_X0 = 8'd10; CMD_Y0 = 7'd20; CMD_W = 8'd2; CMD_H = 7'd2; CMD_COLOUR = 1'b1;
        CMD_VALID = 1'b1;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        repeat (6) @(negedge CLK);
        check_eq("abort_in_weon", {16'd0, BUS_ADDR, BUS_DATA}, 32'hB194);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        check_eq("abort_we_req", {30'd0, BUS_WE, BUS_REQ}, 32'd0);
        check_eq("abort_ready_busy", {30'd0, CMD_READY, BUSY}, 32'd2);
        dcnt = 0;
        repeat (20) begin
            @(negedge CLK);
            if (DONE !== 1'b0) dcnt++;
        end
        check_eq("abort_no_done", dcnt, 32'd0);
        check_eq("abort_nwrites", wlog.size(), 32'd6);

`ifdef VGA_RECT_OUTLINE_EN
        // 3x3 outline at the origin: border only
        run_cmd("outline", 8'd0, 7'd0, 8'd3, 7'd3, 1'b1, 1'b1, lat);
        check_eq("outline_latency", lat, 32'd27);
        check_eq("outline_nwrites", wlog.size(), 32'd25);
        ones = 0;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++)
                if (fb[y][x] === 1'b1) ones++;
        check_eq("outline_border", ones, 32'd8);
        check_eq("outline_centre", {31'd0, fb[1][1]}, 32'd0);
`else
        ones = 0;
`endif
        if (ones < 0) dcnt = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
